mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller between the core and the byte-wide unified RAM/IO bus.
- Serves two clients:
  - the load-store buffer: is_io/is_store/io_addr/io_data/io_op in, mem_res_avail/mem_res/mem_stuck out;
  - the instruction-fetch unit: 32-bit word reads.
- Serialises each access into 1/2/4 byte transfers, assembles and extends load data, and returns one-cycle completion pulses.

Parameters:
- IO_BASE, 32'h30000, first address of the memory-mapped IO window.
- IO_SPAN, 8, size in bytes of the IO window; writes inside it honour io_buffer_full.

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  global enable; low freezes every register.
- rob_clear  in  1  pipeline flush.
- is_io  in  1  LSB request, level-held until completion.
- is_store  in  1  1 = store, 0 = load.
- io_addr  in  32  byte address.
- io_data  in  32  store data (low bytes used).
- io_op  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- mem_res_avail  out  1  one-cycle LSB completion pulse.
- mem_res  out  32  load result, extended; 0 for stores.
- mem_stuck  out  1  controller not IDLE.
- if_req  in  1  fetch request, level-held.
- if_addr  in  32  fetch address.
- if_done  out  1  one-cycle fetch completion pulse.
- if_data  out  32  fetched word.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  RAM write strobe.
- io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset values: state IDLE; mem_a, mem_dout, mem_wr, mem_res, if_data = 0; mem_res_avail, if_done, mem_stuck = 0.
- rdy_in low: all state held; mem_wr output gated to 0.
- States: IDLE, READ, WRITE, DONE. Registers:
  - owner (0 = fetch, 1 = LSB);
  - cnt[2:0], the byte index;
  - len (1/2/4, from io_op[1:0]; fetch = 4);
  - 32-bit assembly buffer.
- IDLE, evaluated at each edge:
  - is_io has priority over if_req.
  - Store accepted: mem_a <= io_addr, mem_dout <= io_data[7:0], mem_wr <= 1, cnt <= 0, go to WRITE.
  - Store to [IO_BASE, IO_BASE+IO_SPAN) while io_buffer_full = 1: not accepted, stay IDLE.
  - Load or fetch accepted: mem_a <= addr, mem_wr <= 0, cnt <= 0, go to READ.
- RAM read latency is 1 cycle: the byte at address A appears on mem_din the cycle after mem_a = A.
- READ, each edge:
  - buffer byte cnt <= mem_din; cnt++; mem_a++.
  - After capturing byte len-1: go to DONE; load mem_res/if_data.
- Load extension:
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw and fetch take the buffer as-is.
- WRITE, each edge:
  - If cnt < len-1: cnt++, mem_a++, mem_dout <= next byte, little-endian.
  - Else: mem_wr <= 0, go to DONE.
- DONE, one cycle:
  - mem_res_avail = (owner == LSB); if_done = (owner == fetch).
  - Next state IDLE; requests are not sampled in DONE, so the still-high is_io/if_req is not re-accepted.
- Latency from accepting edge E0:
  - the pulse is high between E_len and E_len+1;
  - lw/sw/fetch: 4 cycles; lb/sb: 1 cycle.
- mem_stuck = (state != IDLE), combinational.
- rob_clear:
  - READ, either owner: abort to IDLE at that edge with no pulse.
  - WRITE: complete all bytes, then go to IDLE with no pulse; a committed store is never torn.
  - DONE: pulse suppressed.
  - IDLE: no accept that edge.
- Simultaneous is_io and if_req in IDLE: LSB served first; the fetch waits for the next IDLE.
- Reset mid-transfer: immediate return to IDLE; mem_wr drops asynchronously.
- Address arithmetic wraps mod 2^32. Unaligned addresses are legal; bytes are read/written sequentially.

Decomposition:
- Shared const.v gains:
  - state encodings (MEM_IDLE/READ/WRITE/DONE);
  - funct3 load/store width defines;
  - IO_BASE.
- One natural combinational sub-module, mem_ld_ext: buffer + io_op in, extended 32-bit result out.

Test Plan:
- lw 0x100, RAM[0x100..0x103] = 78 56 34 12 → mem_a steps 0x100..0x103; mem_res = 0x12345678, pulsed 4 cycles after accept.
- lb 0x200 with byte 0x80 → mem_res = 0xFFFFFF80; lbu of the same byte → 0x00000080.
- sh 0x300, data 0xABCD → mem_wr high 2 cycles writing CD then AB; mem_res_avail pulse 2 cycles after accept.
- is_io (lw) and if_req raised together → LSB served first, if_done follows LSB completion; no double accept during DONE.
- sb 0x30000 with io_buffer_full = 1 for 5 cycles → no mem_wr until it drops; then write and pulse.
- rob_clear during a fetch READ at byte 2 → no if_done, IDLE next cycle. rob_clear during sw byte 1 → all 4 bytes written, no mem_res_avail.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: state encoding,
// funct3 load/store widths and the IO window base.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_DONE  = 2'd3
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] MEM_IO_BASE = 32'h0003_0000;
  localparam logic [1:0]  FETCH_LAST  = 2'd3;

  // Index of the final byte of an access (transfer length minus one).
  function automatic logic [1:0] last_byte(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_ld_ext.sv
// Load-data extension: picks the significant bytes of the assembly buffer
// and sign- or zero-extends them according to funct3.
module mem_ld_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] buf_i,
  input  logic [2:0]  op_i,
  output logic [31:0] res_o
);

  always_comb begin
    res_o = buf_i;
    case (op_i)
      F3_B:    res_o = {{24{buf_i[7]}}, buf_i[7:0]};
      F3_H:    res_o = {{16{buf_i[15]}}, buf_i[15:0]};
      F3_BU:   res_o = {24'd0, buf_i[7:0]};
      F3_HU:   res_o = {16'd0, buf_i[15:0]};
      default: res_o = buf_i;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: serialises LSB loads/stores and instruction fetches onto
// the byte-wide RAM/IO bus and returns one-cycle completion pulses.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = MEM_IO_BASE,
  parameter int unsigned IO_SPAN = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        is_io,
  input  logic        is_store,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_data,
  input  logic [2:0]  io_op,
  output logic        mem_res_avail,
  output logic [31:0] mem_res,
  output logic        mem_stuck,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mem_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [2:0]  op_q, op_d;
  logic        flush_q, flush_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_res_q, mem_res_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] sdata_q, sdata_d;

  logic [31:0] buf_nxt;
  logic [31:0] ld_ext;
  logic [31:0] io_off;
  logic        io_blocked;

  assign io_off     = io_addr - IO_BASE;
  assign io_blocked = (io_off < 32'(IO_SPAN)) && io_buffer_full;

  mem_ld_ext u_ld_ext (
    .buf_i (buf_nxt),
    .op_i  (op_q),
    .res_o (ld_ext)
  );

  always_comb begin
    buf_nxt = buf_q;
    buf_nxt[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    op_d       = op_q;
    flush_d    = flush_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    mem_res_d  = mem_res_q;
    if_data_d  = if_data_q;
    buf_d      = buf_q;
    sdata_d    = sdata_q;

    case (state_q)
      MEM_IDLE: begin
        flush_d = 1'b0;
        if (!rob_clear) begin
          if (is_io && !(is_store && io_blocked)) begin
            owner_d = 1'b1;
            cnt_d   = 3'd0;
            op_d    = io_op;
            last_d  = last_byte(io_op);
            mem_a_d = io_addr;
            if (is_store) begin
              sdata_d    = io_data;
              mem_dout_d = io_data[7:0];
              mem_wr_d   = 1'b1;
              state_d    = MEM_WRITE;
            end else begin
              mem_wr_d = 1'b0;
              state_d  = MEM_READ;
            end
          end else if (!is_io && if_req) begin
            owner_d  = 1'b0;
            cnt_d    = 3'd0;
            op_d     = F3_W;
            last_d   = FETCH_LAST;
            mem_a_d  = if_addr;
            mem_wr_d = 1'b0;
            state_d  = MEM_READ;
          end
        end
      end

      MEM_READ: begin
        if (rob_clear) begin
          state_d = MEM_IDLE;
        end else begin
          buf_d   = buf_nxt;
          cnt_d   = cnt_q + 3'd1;
          mem_a_d = mem_a_q + 32'd1;
          if (cnt_q == {1'b0, last_q}) begin
            state_d = MEM_DONE;
            if (owner_q) mem_res_d = ld_ext;
            else         if_data_d = buf_nxt;
          end
        end
      end

      // A store that has started is always finished so memory never sees a
      // partial word; a flush only removes the completion pulse.
      MEM_WRITE: begin
        if (rob_clear) flush_d = 1'b1;
        if (cnt_q < {1'b0, last_q}) begin
          cnt_d      = cnt_q + 3'd1;
          mem_a_d    = mem_a_q + 32'd1;
          mem_dout_d = sdata_q[{cnt_d[1:0], 3'b000} +: 8];
        end else begin
          mem_wr_d  = 1'b0;
          mem_res_d = 32'd0;
          state_d   = (flush_q || rob_clear) ? MEM_IDLE : MEM_DONE;
        end
      end

      MEM_DONE: state_d = MEM_IDLE;

      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= MEM_IDLE;
      owner_q    <= 1'b0;
      cnt_q      <= 3'd0;
      last_q     <= 2'd0;
      op_q       <= F3_W;
      flush_q    <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      mem_res_q  <= 32'd0;
      if_data_q  <= 32'd0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      op_q       <= op_d;
      flush_q    <= flush_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      mem_res_q  <= mem_res_d;
      if_data_q  <= if_data_d;
    end
  end

  // Assembly and store-data buffers carry no control meaning, so no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      buf_q   <= buf_d;
      sdata_q <= sdata_d;
    end
  end

  assign mem_a         = mem_a_q;
  assign mem_dout      = mem_dout_q;
  assign mem_wr        = mem_wr_q && rdy_in;
  assign mem_res       = mem_res_q;
  assign if_data       = if_data_q;
  assign mem_stuck     = (state_q != MEM_IDLE);
  assign mem_res_avail = (state_q == MEM_DONE) && owner_q && !rob_clear && rdy_in;
  assign if_done       = (state_q == MEM_DONE) && !owner_q && !rob_clear && rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-addressed RAM model, write log and a word-level
// reference model for loads, stores and fetches.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        rob_clear = 1'b0;
  logic        is_io = 1'b0;
  logic        is_store = 1'b0;
  logic [31:0] io_addr = '0;
  logic [31:0] io_data = '0;
  logic [2:0]  io_op = '0;
  logic        mem_res_avail;
  logic [31:0] mem_res;
  logic        mem_stuck;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  logic [7:0]  ram [4096];
  logic [39:0] wlog [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy),
    .rob_clear      (rob_clear),
    .is_io          (is_io),
    .is_store       (is_store),
    .io_addr        (io_addr),
    .io_data        (io_data),
    .io_op          (io_op),
    .mem_res_avail  (mem_res_avail),
    .mem_res        (mem_res),
    .mem_stuck      (mem_stuck),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  // Byte addressed in the cycle mem_a holds it is captured at the next edge.
  assign mem_din = ram[mem_a[11:0]];

  always @(posedge clk) if (mem_wr) wlog.push_back({mem_a, mem_dout});

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int op_len(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
    longint w = 0;
    longint v;
    for (int i = 0; i < 4; i++) w += longint'(ram[(a + 32'(i)) & 32'hFFF]) << (8 * i);
    case (op)
      3'b000: begin v = w % 256;   if (v >= 128)   v -= 256;   end
      3'b001: begin v = w % 65536; if (v >= 32768) v -= 65536; end
      3'b100: v = w % 256;
      3'b101: v = w % 65536;
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  // Counts edges from the accepting edge until the pulse is seen at a negedge.
  task automatic wait_pulse(input bit lsb, output int lat);
    int cyc = 0;
    lat = -1;
    while (cyc < 40) begin
      @(posedge clk); @(negedge clk); cyc++;
      if ((lsb && mem_res_avail) || (!lsb && if_done)) begin
        lat = cyc - 1;
        break;
      end
    end
  endtask

  task automatic lsb_op(input string tag, input bit st, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] op);
    int lat;
    int base;
    int len;
    len = op_len(op);
    base = wlog.size();
    @(negedge clk);
    is_io = 1'b1; is_store = st; io_addr = a; io_data = d; io_op = op;
    wait_pulse(1'b1, lat);
    chk({tag, "_lat"}, 40'(lat), 40'(len));
    chk({tag, "_res"}, {8'h0, mem_res}, st ? 40'h0 : {8'h0, ref_load(a, op)});
    is_io = 1'b0;
    if (st) begin
      chk({tag, "_nwr"}, 40'(wlog.size() - base), 40'(len));
      for (int i = 0; i < len && base + i < wlog.size(); i++)
        chk({tag, "_wr"}, wlog[base + i], {a + 32'(i), d[8 * i +: 8]});
    end
  endtask

  task automatic fetch_op(input string tag, input logic [31:0] a);
    int lat;
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    wait_pulse(1'b0, lat);
    chk({tag, "_lat"}, 40'(lat), 40'd4);
    chk({tag, "_data"}, {8'h0, if_data}, {8'h0, ref_load(a, 3'b010)});
    if_req = 1'b0;
  endtask

  initial begin
    int lat;
    int base;
    int hits;
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100; ops[4] = 3'b101;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    ram[12'h200] = 8'h80;

    #12;
    chk("rst_stuck", 40'(mem_stuck), 40'd0);
    chk("rst_wr", 40'(mem_wr), 40'd0);
    chk("rst_a", {8'h0, mem_a}, 40'h0);
    chk("rst_dout", 40'(mem_dout), 40'h0);
    chk("rst_res", {8'h0, mem_res}, 40'h0);
    chk("rst_ifdata", {8'h0, if_data}, 40'h0);
    chk("rst_pulses", {38'h0, mem_res_avail, if_done}, 40'h0);
    @(negedge clk); rst_n = 1'b1;

    // lw 0x100 with address stepping
    @(negedge clk);
    is_io = 1'b1; is_store = 1'b0; io_addr = 32'h100; io_op = 3'b010;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("lw_addr", {8'h0, mem_a}, {8'h0, 32'h100 + 32'(i)});
    end
    @(posedge clk); @(negedge clk);
    chk("lw_pulse", 40'(mem_res_avail), 40'd1);
    chk("lw_res", {8'h0, mem_res}, 40'h0012345678);
    is_io = 1'b0;

    lsb_op("lb", 1'b0, 32'h200, 32'h0, 3'b000);
    chk("lb_val", {8'h0, mem_res}, 40'h00FFFFFF80);
    lsb_op("lbu", 1'b0, 32'h200, 32'h0, 3'b100);
    chk("lbu_val", {8'h0, mem_res}, 40'h0000000080);
    lsb_op("sh", 1'b1, 32'h300, 32'h0000ABCD, 3'b001);
    lsb_op("lw_wrap", 1'b0, 32'hFFFFFFFE, 32'h0, 3'b010);

    // simultaneous LSB load and fetch
    @(negedge clk);
    is_io = 1'b1; is_store = 1'b0; io_addr = 32'h104; io_op = 3'b010;
    if_req = 1'b1; if_addr = 32'h40;
    hits = 0;
    wait_pulse(1'b1, lat);
    chk("both_lsb_lat", 40'(lat), 40'd4);
    chk("both_no_ifdone", 40'(if_done), 40'd0);
    chk("both_lsb_res", {8'h0, mem_res}, {8'h0, ref_load(32'h104, 3'b010)});
    @(posedge clk); @(negedge clk);
    chk("done_no_reaccept", 40'(mem_stuck), 40'd0);
    is_io = 1'b0;
    wait_pulse(1'b0, lat);
    chk("both_if_lat", 40'(lat), 40'd4);
    chk("both_if_data", {8'h0, if_data}, {8'h0, ref_load(32'h40, 3'b010)});
    if_req = 1'b0;

    // sb into the IO window while the UART buffer is full
    base = wlog.size();
    @(negedge clk);
    io_buffer_full = 1'b1;
    is_io = 1'b1; is_store = 1'b1; io_addr = 32'h30000; io_data = 32'h5A; io_op = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      hits += int'(mem_wr) + int'(mem_stuck);
    end
    chk("iofull_blocked", 40'(hits), 40'd0);
    chk("iofull_nolog", 40'(wlog.size() - base), 40'd0);
    io_buffer_full = 1'b0;
    wait_pulse(1'b1, lat);
    chk("iofull_lat", 40'(lat), 40'd1);
    chk("iofull_wr", (wlog.size() == base + 1) ? wlog[base] : 40'hX, {32'h30000, 8'h5A});
    is_io = 1'b0;

    // flush during fetch READ at byte 2
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h500;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rob_clear = 1'b1; if_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("fl_rd_idle", 40'(mem_stuck), 40'd0);
    chk("fl_rd_nodone", 40'(if_done), 40'd0);
    rob_clear = 1'b0;
    hits = 0;
    repeat (6) begin @(posedge clk); @(negedge clk); hits += int'(if_done); end
    chk("fl_rd_nopulse", 40'(hits), 40'd0);

    // flush during sw byte 1
    base = wlog.size();
    @(negedge clk);
    is_io = 1'b1; is_store = 1'b1; io_addr = 32'h600; io_data = 32'hDEADBEEF; io_op = 3'b010;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rob_clear = 1'b1; is_io = 1'b0; io_data = 32'h0;
    @(posedge clk); @(negedge clk);
    rob_clear = 1'b0;
    hits = 0;
    repeat (8) begin @(posedge clk); @(negedge clk); hits += int'(mem_res_avail); end
    chk("fl_wr_nopulse", 40'(hits), 40'd0);
    chk("fl_wr_nbytes", 40'(wlog.size() - base), 40'd4);
    for (int i = 0; i < 4 && base + i < wlog.size(); i++)
      chk("fl_wr_byte", wlog[base + i], {32'h600 + 32'(i), 8'(32'hDEADBEEF >> (8 * i))});
    chk("fl_wr_idle", 40'(mem_stuck), 40'd0);

    // reset in the middle of a store
    base = wlog.size();
    @(negedge clk);
    is_io = 1'b1; is_store = 1'b1; io_addr = 32'h700; io_data = 32'h11223344; io_op = 3'b010;
    @(posedge clk); #2;
    chk("mid_wr_active", 40'(mem_wr), 40'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_wr", 40'(mem_wr), 40'd0);
    chk("mid_rst_stuck", 40'(mem_stuck), 40'd0);
    is_io = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("mid_rst_nolog", 40'(wlog.size() - base), 40'd0);

    // randomized mix against the reference model
    for (int k = 0; k < 30; k++) begin
      int kind;
      logic [31:0] a;
      logic [31:0] d;
      kind = int'($urandom_range(0, 2));
      a = $urandom;
      d = $urandom;
      if (kind == 0) lsb_op("rnd_ld", 1'b0, a, 32'h0, ops[$urandom_range(0, 4)]);
      else if (kind == 1) lsb_op("rnd_st", 1'b1, a, d, ops[$urandom_range(0, 2)]);
      else fetch_op("rnd_if", a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
